// File: rtl/param_frame_pkg.sv
// Shared definitions for the parameter-load frame transmitter: FSM states,
// frame geometry, control-bus bit positions and the payload byte selector.
package param_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam int FRAME_LEN = 10;
    localparam logic [3:0] CHK_IDX = 4'(FRAME_LEN - 1);

    localparam int CTRL_VALID   = 0;
    localparam int CTRL_SOF     = 1;
    localparam int CTRL_EOF     = 2;
    localparam int CTRL_IDX_LSB = 3;
    localparam int CTRL_IDX_MSB = 6;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // Bytes 1-4 carry w0 and bytes 5-8 carry w1, both most significant byte first.
    function automatic logic [7:0] payload_byte(input logic [31:0] w0,
                                                input logic [31:0] w1,
                                                input logic [3:0]  idx);
        logic [7:0] b;
        case (idx)
            4'd1:    b = w0[31:24];
            4'd2:    b = w0[23:16];
            4'd3:    b = w0[15:8];
            4'd4:    b = w0[7:0];
            4'd5:    b = w1[31:24];
            4'd6:    b = w1[23:16];
            4'd7:    b = w1[15:8];
            4'd8:    b = w1[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/crc8_byte_step.sv
// One-byte CRC-8 update (poly 0x07, MSB first, no reflection); used by
// param_frame_tx only when PARAM_FRAME_CRC8_EN is defined.
module crc8_byte_step
    import param_frame_pkg::*;
(
    input  logic [7:0] crc,
    input  logic [7:0] data_in,
    output logic [7:0] next_crc
);

    logic [7:0] acc;

    always_comb begin
        acc = crc ^ data_in;
        for (int i = 0; i < 8; i++) begin
            acc = acc[7] ? ((acc << 1) ^ CRC8_POLY) : (acc << 1);
        end
        next_crc = acc;
    end

endmodule

// File: rtl/param_frame_tx.sv
// Parameter-load frame transmitter: header, a0, a1 (MSB first) and a check byte.
// Check byte is XOR of payload bytes, or CRC-8 when PARAM_FRAME_CRC8_EN is defined.
module param_frame_tx
    import param_frame_pkg::*;
#(
    parameter int         GAP_CYCLES = 2,
    parameter logic [7:0] HDR_BYTE   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        start,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic        rx_busy,
    output logic        busy,
    output logic        done,
    output logic [7:0]  out_data,
    output logic [7:0]  out_ctrl
);

    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    state_t             state;
    logic [3:0]         idx;
    logic [3:0]         send_idx;
    logic [GAP_W-1:0]   gap_cnt;
    logic [31:0]        a0_q;
    logic [31:0]        a1_q;
    logic [7:0]         chk;
    logic [7:0]         chk_next;
    logic [7:0]         send_byte;
    logic               load_now;

    logic               busy_q;
    logic               done_q;
    logic               valid_q;
    logic               sof_q;
    logic               eof_q;
    logic [7:0]         data_q;
    logic [3:0]         out_idx_q;

    // In SEND the next byte is idx+1, which lets GAP_CYCLES=0 strobe back-to-back.
    always_comb begin
        send_idx = (state == ST_SEND) ? idx + 4'd1 : idx;
        if (send_idx == 4'd0) begin
            send_byte = HDR_BYTE;
        end else if (send_idx == CHK_IDX) begin
            send_byte = chk;
        end else begin
            send_byte = payload_byte(a0_q, a1_q, send_idx);
        end
    end

`ifdef PARAM_FRAME_CRC8_EN
    crc8_byte_step u_crc8 (
        .crc      (chk),
        .data_in  (send_byte),
        .next_crc (chk_next)
    );
`else
    assign chk_next = chk ^ send_byte;
`endif

    // Every path that reaches the ready check (WAIT_RDY, end of gap, or a gapless SEND)
    // launches the next byte in the same cycle when the receiver is free.
    always_comb begin
        load_now = 1'b0;
        if (!rx_busy) begin
            case (state)
                ST_WAIT_RDY: load_now = 1'b1;
                ST_SEND:     load_now = (GAP_CYCLES == 0) && (idx != CHK_IDX);
                ST_GAP:      load_now = (gap_cnt == GAP_W'(GAP_LAST));
                default:     load_now = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            gap_cnt   <= '0;
            a0_q      <= '0;
            a1_q      <= '0;
            chk       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            data_q    <= '0;
            out_idx_q <= '0;
        end else if (ena) begin
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a0_q    <= a0;
                        a1_q    <= a1;
                        chk     <= '0;
                        idx     <= '0;
                        gap_cnt <= '0;
                        busy_q  <= 1'b1;
                        state   <= ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: begin
                    state <= ST_WAIT_RDY;
                end
                ST_SEND: begin
                    if (idx == CHK_IDX) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else if (GAP_CYCLES == 0) begin
                        idx   <= send_idx;
                        state <= ST_WAIT_RDY;
                    end else begin
                        idx     <= send_idx;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_LAST)) begin
                        state <= ST_WAIT_RDY;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Header and check byte are not folded into the running check value.
            if (load_now) begin
                state     <= ST_SEND;
                idx       <= send_idx;
                valid_q   <= 1'b1;
                sof_q     <= (send_idx == 4'd0);
                eof_q     <= (send_idx == CHK_IDX);
                data_q    <= send_byte;
                out_idx_q <= send_idx;
                if ((send_idx != 4'd0) && (send_idx != CHK_IDX)) begin
                    chk <= chk_next;
                end
            end
        end
    end

    // Strobes are masked by ena directly so a frozen SEND cycle shows nothing and
    // reappears once ena returns.
    always_comb begin
        out_ctrl                            = '0;
        out_ctrl[CTRL_VALID]                = valid_q & ena;
        out_ctrl[CTRL_SOF]                  = sof_q & ena;
        out_ctrl[CTRL_EOF]                  = eof_q & ena;
        out_ctrl[CTRL_IDX_MSB:CTRL_IDX_LSB] = out_idx_q;
    end

    assign busy     = busy_q;
    assign done     = done_q & ena;
    assign out_data = data_q;

endmodule

// File: tb/tb_param_frame_tx.sv
// Bench for param_frame_tx: a GAP_CYCLES=2 instance for the main scenarios and a
// GAP_CYCLES=0 instance for back-to-back framing, both checked against a frame model.
module tb_param_frame_tx;

    typedef logic [9:0][7:0] frame_t;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        start;
    logic        start0;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        rx_busy;

    logic        busy_a, done_a, busy_b, done_b;
    logic [7:0]  data_a, ctrl_a, data_b, ctrl_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_bytes [2][10];
    logic [7:0] strb_data [2][10];
    int         strb_cyc  [2][10];
    int         pos       [2];
    bit         active    [2];
    int         done_cyc  [2];
    int         done_cnt  [2];
    int         strobe_cnt[2];

    param_frame_tx #(.GAP_CYCLES(2), .HDR_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .a0(a0), .a1(a1),
        .rx_busy(rx_busy), .busy(busy_a), .done(done_a), .out_data(data_a), .out_ctrl(ctrl_a)
    );

    param_frame_tx #(.GAP_CYCLES(0), .HDR_BYTE(8'hA5)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start0), .a0(a0), .a1(a1),
        .rx_busy(rx_busy), .busy(busy_b), .done(done_b), .out_data(data_b), .out_ctrl(ctrl_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Frame contents straight from the layout rules: header, 8 payload bytes, check byte.
    function automatic frame_t model_frame(input logic [31:0] w0, input logic [31:0] w1);
        frame_t      f;
        logic [63:0] pl;
        logic [7:0]  c;
        pl   = {w0, w1};
        c    = 8'h00;
        f[0] = 8'hA5;
        for (int k = 1; k <= 8; k++) begin
            f[k] = pl[63 - 8 * (k - 1) -: 8];
`ifdef PARAM_FRAME_CRC8_EN
            c = c ^ f[k];
            for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
`else
            c = c ^ f[k];
`endif
        end
        f[9] = c;
        return f;
    endfunction

    task automatic expect_frame(input int id, input logic [31:0] w0, input logic [31:0] w1);
        frame_t f;
        f = model_frame(w0, w1);
        for (int k = 0; k < 10; k++) begin
            exp_bytes[id][k] = f[k];
            strb_cyc[id][k]  = -1;
        end
        pos[id]    = 0;
        active[id] = 1'b1;
    endtask

    task automatic monitor_inst(input int id, input logic [7:0] ctrl, input logic [7:0] data,
                                input logic dn);
        string tag;
        tag = (id == 0) ? "g2" : "g0";
        check_output({tag, "_ctrl_bit7"}, ctrl[7], 1'b0);
        if (!ena) check_output({tag, "_strobe_while_ena_low"}, {ctrl[2:0], dn}, 4'h0);
        if (rx_busy && id == 0) check_output({tag, "_valid_while_rx_busy"}, ctrl[0], 1'b0);
        if (ctrl[0] === 1'b1) begin
            strobe_cnt[id]++;
            if (!active[id] || pos[id] > 9) begin
                check_output({tag, "_unexpected_strobe"}, ctrl[0], 1'b0);
            end else begin
                check_output($sformatf("%s_byte%0d_data", tag, pos[id]), data, exp_bytes[id][pos[id]]);
                check_output($sformatf("%s_byte%0d_sof", tag, pos[id]), ctrl[1], pos[id] == 0);
                check_output($sformatf("%s_byte%0d_eof", tag, pos[id]), ctrl[2], pos[id] == 9);
                check_output($sformatf("%s_byte%0d_idx", tag, pos[id]), ctrl[6:3], pos[id]);
                strb_cyc[id][pos[id]]  = cyc;
                strb_data[id][pos[id]] = data;
                pos[id]++;
            end
        end
        if (dn === 1'b1) begin
            done_cnt[id]++;
            done_cyc[id] = cyc;
            if (!active[id]) begin
                check_output({tag, "_unexpected_done"}, dn, 1'b0);
            end else begin
                check_output({tag, "_done_after_last_byte"}, pos[id], 10);
                active[id] = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        monitor_inst(0, ctrl_a, data_a, done_a);
        monitor_inst(1, ctrl_b, data_b, done_b);
    end

    task automatic goto_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input int id, input logic [31:0] w0, input logic [31:0] w1,
                                  output int t);
        a0 = w0;
        a1 = w1;
        if (id == 0) start = 1'b1;
        else start0 = 1'b1;
        expect_frame(id, w0, w1);
        t = cyc + 1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        start0 = 1'b0;
    endtask

    task automatic wait_done(input int id, input int budget, input string tag);
        int n;
        n = 0;
        while (active[id] && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output({tag, "_frame_completes"}, active[id], 1'b0);
    endtask

    task automatic check_timing(input int id, input int t, input int gap, input int stall_k,
                                input int stall_len, input string tag);
        for (int k = 0; k < 10; k++) begin
            check_output($sformatf("%s_strobe%0d_cycle", tag, k), strb_cyc[id][k],
                         t + 1 + k * (gap + 1) + ((k >= stall_k) ? stall_len : 0));
        end
        check_output({tag, "_done_cycle"}, done_cyc[id], t + 1 + 9 * (gap + 1) + stall_len + 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_busy"}, {busy_b, busy_a}, 2'b00);
        check_output({tag, "_done"}, {done_b, done_a}, 2'b00);
        check_output({tag, "_data"}, {data_b, data_a}, 16'h0000);
        check_output({tag, "_ctrl"}, {ctrl_b, ctrl_a}, 16'h0000);
    endtask

    initial begin
        frame_t f;
        int     t;
        int     snap_done;
        int     snap_strobe;

        for (int i = 0; i < 2; i++) begin
            pos[i] = 0; active[i] = 1'b0; done_cyc[i] = -1; done_cnt[i] = 0; strobe_cnt[i] = 0;
        end
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; start0 = 1'b0;
        a0 = '0; a1 = '0; rx_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Hand-computed frames pin the model itself.
        f = model_frame(32'h12345678, 32'h9ABCDEF0);
        check_output("model_hdr", f[0], 8'hA5);
        check_output("model_payload_hi", {f[1], f[2], f[3], f[4]}, 32'h12345678);
        check_output("model_payload_lo", {f[5], f[6], f[7], f[8]}, 32'h9ABCDEF0);
`ifndef PARAM_FRAME_CRC8_EN
        check_output("model_basic_chk", f[9], 8'h00);
`endif
        f = model_frame(32'h0, 32'h1);
`ifdef PARAM_FRAME_CRC8_EN
        check_output("model_vec_chk", f[9], 8'h07);
`else
        check_output("model_vec_chk", f[9], 8'h01);
`endif

        $display("[TB] basic frame");
        apply_stimulus(0, 32'h12345678, 32'h9ABCDEF0, t);
        wait_done(0, 60, "basic");
        check_timing(0, t, 2, 10, 0, "basic");
        check_output("basic_busy_after", busy_a, 1'b0);

        $display("[TB] back-pressure before byte 3");
        apply_stimulus(0, 32'h12345678, 32'h9ABCDEF0, t);
        goto_cycle(t + 9);
        rx_busy = 1'b1;
        goto_cycle(t + 14);
        rx_busy = 1'b0;
        wait_done(0, 60, "bp");
        check_timing(0, t, 2, 3, 5, "bp");

        $display("[TB] check byte vector");
        apply_stimulus(0, 32'h00000000, 32'h00000001, t);
        wait_done(0, 60, "chkvec");
        check_timing(0, t, 2, 10, 0, "chkvec");
`ifdef PARAM_FRAME_CRC8_EN
        check_output("chkvec_byte9", strb_data[0][9], 8'h07);
`else
        check_output("chkvec_byte9", strb_data[0][9], 8'h01);
`endif

        $display("[TB] enable freeze on byte 5");
        apply_stimulus(0, 32'h12345678, 32'h9ABCDEF0, t);
        goto_cycle(t + 16);
        ena = 1'b0;
        goto_cycle(t + 19);
        ena = 1'b1;
        wait_done(0, 60, "ena");
        check_timing(0, t, 2, 5, 3, "ena");
        check_output("ena_byte5_value", strb_data[0][5], 8'h9A);

        $display("[TB] start blocked while ena low");
        snap_strobe = strobe_cnt[0];
        ena = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ena = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        check_output("ena_low_start_strobes", strobe_cnt[0], snap_strobe);
        check_output("ena_low_start_busy", busy_a, 1'b0);

        $display("[TB] reset at byte 4");
        snap_done = done_cnt[0];
        apply_stimulus(0, 32'h12345678, 32'h9ABCDEF0, t);
        goto_cycle(t + 13);
        rst_n = 1'b0;
        goto_cycle(t + 14);
        check_idle_outputs("midreset");
        active[0] = 1'b0;
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        check_output("midreset_no_done", done_cnt[0], snap_done);
        check_output("midreset_bytes_sent", pos[0], 5);

        $display("[TB] fresh frame with ignored starts");
        apply_stimulus(0, 32'hCAFEF00D, 32'h8000007F, t);
        goto_cycle(t + 5);
        a0 = 32'hFFFFFFFF;
        a1 = 32'h00000000;
        start = 1'b1;
        goto_cycle(t + 6);
        start = 1'b0;
        goto_cycle(t + 29);
        start = 1'b1;
        goto_cycle(t + 30);
        start = 1'b0;
        wait_done(0, 60, "fresh");
        check_timing(0, t, 2, 10, 0, "fresh");
        snap_strobe = strobe_cnt[0];
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        check_output("ignored_start_strobes", strobe_cnt[0], snap_strobe);
        check_output("ignored_start_busy", busy_a, 1'b0);

        $display("[TB] gapless frame");
        apply_stimulus(1, 32'h12345678, 32'h9ABCDEF0, t);
        wait_done(1, 30, "gap0");
        check_timing(1, t, 0, 10, 0, "gap0");
        check_output("gap0_strobe_count", strobe_cnt[1], 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
